// File: rtl/csr_reg_file.sv
// csr_reg_file: machine-mode CSR block with interrupt trap entry and mret.
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   addr       CSR address (instruction bits [31:20])
//   wdata      CSR write data (rs1 value)
//   pc         PC of the instruction presenting csr_rd/csr_wr/is_mret
//   csr_rd     read strobe; rdata is zero when low
//   csr_wr     write strobe
//   is_mret    current instruction is mret
//   timer_irq  level timer interrupt request
//   ext_irq    level external interrupt request
//   rdata      combinational CSR read data
//   epc_taken  one-cycle PC redirect request
//   epc        redirect target, zero unless epc_taken is high
module csr_reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  input  logic        csr_rd,
  input  logic        csr_wr,
  input  logic        is_mret,
  input  logic        timer_irq,
  input  logic        ext_irq,
  output logic [31:0] rdata,
  output logic        epc_taken,
  output logic [31:0] epc
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  localparam logic [31:0] WORD_ALIGN = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRAP = 2'd1,
    RET  = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_next_s;

  logic        mstatus_mie_r;
  logic        mstatus_mpie_r;
  logic        mie_mtie_r;
  logic        mie_meie_r;
  logic [31:0] mtvec_r;
  logic [31:0] mepc_r;
  logic [31:0] mcause_r;
  logic        mip_mtip_r;
  logic        mip_meip_r;

  logic        pending_s;
  logic [3:0]  cause_s;
  logic        take_trap_s;
  logic        do_mret_s;
  logic        wr_en_s;
  logic [31:0] mepc_next_s;

  // Trap vector: direct mode jumps to the base, vectored mode adds 4*cause.
  function automatic logic [31:0] trap_target(input logic [31:0] tvec,
                                              input logic [3:0]  cause);
    logic [31:0] base;
    base = tvec & WORD_ALIGN;
    if (tvec[1:0] == 2'b00) begin
      trap_target = base;
    end else begin
      trap_target = base + {26'd0, cause, 2'b00};
    end
  endfunction

  assign pending_s = mstatus_mie_r &
                     ((mie_mtie_r & mip_mtip_r) | (mie_meie_r & mip_meip_r));
  // External interrupt outranks the timer.
  assign cause_s   = (mie_meie_r & mip_meip_r) ? 4'd11 : 4'd7;

  // Next-state decode and the per-cycle action strobes.
  always_comb begin
    state_next_s = state_r;
    take_trap_s  = 1'b0;
    do_mret_s    = 1'b0;
    wr_en_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (is_mret) begin
          // mret wins over a pending interrupt in the same cycle.
          do_mret_s    = 1'b1;
          wr_en_s      = csr_wr;
          state_next_s = RET;
        end else if (pending_s) begin
          // The instruction is abandoned, so its CSR write is dropped.
          take_trap_s  = 1'b1;
          state_next_s = TRAP;
        end else begin
          wr_en_s      = csr_wr;
          state_next_s = IDLE;
        end
      end
      TRAP:    state_next_s = IDLE;
      RET:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // mepc value as it will stand after this edge (used for the mret target).
  always_comb begin
    mepc_next_s = mepc_r;
    if (wr_en_s && (addr == ADDR_MEPC)) begin
      mepc_next_s = wdata & WORD_ALIGN;
    end else begin
      mepc_next_s = mepc_r;
    end
  end

  // Combinational CSR read mux; zero when not reading or unimplemented.
  always_comb begin
    rdata = 32'd0;
    if (csr_rd) begin
      case (addr)
        ADDR_MSTATUS: rdata = {24'd0, mstatus_mpie_r, 3'd0, mstatus_mie_r, 3'd0};
        ADDR_MIE:     rdata = {20'd0, mie_meie_r, 3'd0, mie_mtie_r, 7'd0};
        ADDR_MTVEC:   rdata = mtvec_r;
        ADDR_MEPC:    rdata = mepc_r;
        ADDR_MCAUSE:  rdata = mcause_r;
        ADDR_MIP:     rdata = {20'd0, mip_meip_r, 3'd0, mip_mtip_r, 7'd0};
        default:      rdata = 32'd0;
      endcase
    end else begin
      rdata = 32'd0;
    end
  end

  // State, CSR and redirect-output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      mstatus_mie_r  <= 1'b0;
      mstatus_mpie_r <= 1'b0;
      mie_mtie_r     <= 1'b0;
      mie_meie_r     <= 1'b0;
      mtvec_r        <= 32'd0;
      mepc_r         <= 32'd0;
      mcause_r       <= 32'd0;
      mip_mtip_r     <= 1'b0;
      mip_meip_r     <= 1'b0;
      epc_taken      <= 1'b0;
      epc            <= 32'd0;
    end else begin
      state_r    <= state_next_s;
      mip_mtip_r <= timer_irq;
      mip_meip_r <= ext_irq;

      if (take_trap_s) begin
        mepc_r         <= pc & WORD_ALIGN;
        mcause_r       <= {1'b1, 27'd0, cause_s};
        mstatus_mpie_r <= mstatus_mie_r;
        mstatus_mie_r  <= 1'b0;
      end else begin
        if (wr_en_s) begin
          case (addr)
            ADDR_MSTATUS: begin
              mstatus_mie_r  <= wdata[3];
              mstatus_mpie_r <= wdata[7];
            end
            ADDR_MIE: begin
              mie_mtie_r <= wdata[7];
              mie_meie_r <= wdata[11];
            end
            ADDR_MTVEC:  mtvec_r  <= wdata;
            ADDR_MEPC:   mepc_r   <= mepc_next_s;
            ADDR_MCAUSE: mcause_r <= wdata;
            default: begin
            end
          endcase
        end else begin
        end
        // Placed after the write so mret's mstatus update takes precedence.
        if (do_mret_s) begin
          mstatus_mie_r  <= mstatus_mpie_r;
          mstatus_mpie_r <= 1'b1;
        end else begin
        end
      end

      // Redirect outputs are registered so they are valid for the whole
      // TRAP/RET cycle; mtvec cannot change on a trap edge.
      case (state_next_s)
        TRAP: begin
          epc_taken <= 1'b1;
          epc       <= trap_target(mtvec_r, cause_s);
        end
        RET: begin
          epc_taken <= 1'b1;
          epc       <= mepc_next_s;
        end
        default: begin
          epc_taken <= 1'b0;
          epc       <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_reg_file.sv
module tb_csr_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [31:0] pc;
  logic        csr_rd;
  logic        csr_wr;
  logic        is_mret;
  logic        timer_irq;
  logic        ext_irq;
  logic [31:0] rdata;
  logic        epc_taken;
  logic [31:0] epc;

  int n_cmp  = 0;
  int n_fail = 0;

  csr_reg_file dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .pc(pc),
    .csr_rd(csr_rd), .csr_wr(csr_wr), .is_mret(is_mret),
    .timer_irq(timer_irq), .ext_irq(ext_irq),
    .rdata(rdata), .epc_taken(epc_taken), .epc(epc)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (word-level CSR images) ----------------
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_mip;
  logic        m_busy, m_taken, m_valid;
  logic [31:0] m_epc;

  initial m_valid = 1'b0;

  function automatic logic [31:0] m_read(input logic rd, input logic [11:0] a);
    if (!rd) return 32'd0;
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return m_mip;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic [31:0] s, ie, tv, ep, ca, ip, tgt;
    logic        busy, tk;
    logic [31:0] cause;
    s = m_mstatus; ie = m_mie; tv = m_mtvec; ep = m_mepc; ca = m_mcause;
    ip = m_mip; busy = m_busy; tk = 1'b0; tgt = 32'd0;
    if (rst) begin
      s = 0; ie = 0; tv = 0; ep = 0; ca = 0; ip = 0; busy = 0;
    end else begin
      if (!busy) begin
        if (is_mret) begin
          if (csr_wr) begin
            case (addr)
              12'h304: ie = wdata & 32'h880;
              12'h305: tv = wdata;
              12'h341: ep = wdata & ~32'd3;
              12'h342: ca = wdata;
              default: ;
            endcase
          end
          s = (m_mstatus[7] ? 32'h8 : 32'h0) | 32'h80;
          tk = 1'b1; tgt = ep; busy = 1'b1;
        end else if (m_mstatus[3] && ((m_mie & m_mip & 32'h880) != 0)) begin
          cause = ((m_mie & m_mip & 32'h800) != 0) ? 32'd11 : 32'd7;
          ep = pc & ~32'd3;
          ca = 32'h8000_0000 | cause;
          s = m_mstatus[3] ? 32'h80 : 32'h0;
          tgt = (m_mtvec & ~32'd3) + (((m_mtvec & 32'd3) != 0) ? 4 * cause : 32'd0);
          tk = 1'b1; busy = 1'b1;
        end else if (csr_wr) begin
          case (addr)
            12'h300: s  = wdata & 32'h88;
            12'h304: ie = wdata & 32'h880;
            12'h305: tv = wdata;
            12'h341: ep = wdata & ~32'd3;
            12'h342: ca = wdata;
            default: ;
          endcase
        end
      end else begin
        busy = 1'b0;
      end
      ip = (timer_irq ? 32'h80 : 32'h0) | (ext_irq ? 32'h800 : 32'h0);
    end
    m_mstatus <= s; m_mie <= ie; m_mtvec <= tv; m_mepc <= ep; m_mcause <= ca;
    m_mip <= ip; m_busy <= busy; m_taken <= tk; m_epc <= tgt;
    m_valid <= 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_rdata", rdata, m_read(csr_rd, addr));
      check("model_epc_taken", {31'd0, epc_taken}, {31'd0, m_taken});
      check("model_epc", epc, m_epc);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_wr = 1'b1; csr_rd = 1'b0; addr = a; wdata = d;
    tick();
    csr_wr = 1'b0;
  endtask

  task automatic rd_check(input logic [11:0] a, input logic [31:0] exp, input string name);
    csr_rd = 1'b1; csr_wr = 1'b0; addr = a;
    @(negedge clk);
    check(name, rdata, exp);
    tick();
    csr_rd = 1'b0;
  endtask

  task automatic redir_check(input logic t, input logic [31:0] e, input string name);
    @(negedge clk);
    check({name, "_taken"}, {31'd0, epc_taken}, {31'd0, t});
    check({name, "_epc"}, epc, e);
    tick();
  endtask

  initial begin
    rst = 1'b1; addr = 12'd0; wdata = 32'd0; pc = 32'd0; csr_rd = 1'b0;
    csr_wr = 1'b0; is_mret = 1'b0; timer_irq = 1'b0; ext_irq = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    redir_check(1'b0, 32'd0, "reset");
    rd_check(12'h300, 32'd0, "reset_mstatus");

    // Basic write/read and mepc masking
    wr(12'h305, 32'h0000_1001);
    rd_check(12'h305, 32'h0000_1001, "mtvec_rw");
    wr(12'h341, 32'h0000_2003);
    rd_check(12'h341, 32'h0000_2000, "mepc_mask");

    // Same-cycle read+write returns the old value, new one next cycle
    csr_rd = 1'b1; csr_wr = 1'b1; addr = 12'h342; wdata = 32'h0000_0055;
    @(negedge clk);
    check("rdw_old", rdata, 32'd0);
    tick();
    csr_wr = 1'b0;
    rd_check(12'h342, 32'h0000_0055, "rdw_new");

    // Read-only bits, mip and unimplemented addresses
    wr(12'h300, 32'hFFFF_FFFF);
    rd_check(12'h300, 32'h0000_0088, "mstatus_mask");
    wr(12'h300, 32'h0000_0000);
    wr(12'h304, 32'hFFFF_FFFF);
    rd_check(12'h304, 32'h0000_0880, "mie_mask");
    wr(12'h123, 32'hFFFF_FFFF);
    rd_check(12'h123, 32'd0, "unimpl");
    wr(12'h344, 32'hFFFF_FFFF);
    rd_check(12'h344, 32'd0, "mip_ro");
    timer_irq = 1'b1;
    tick();
    rd_check(12'h344, 32'h0000_0080, "mip_latency");
    timer_irq = 1'b0;
    tick();

    // Timer trap, direct mode
    wr(12'h300, 32'h8); wr(12'h304, 32'h80); wr(12'h305, 32'h100);
    pc = 32'h40; timer_irq = 1'b1;
    tick();
    redir_check(1'b0, 32'd0, "pre_trap");
    timer_irq = 1'b0;
    redir_check(1'b1, 32'h100, "trap_timer");
    rd_check(12'h341, 32'h40, "trap_mepc");
    rd_check(12'h342, 32'h8000_0007, "trap_mcause");
    rd_check(12'h300, 32'h80, "trap_mstatus");

    // mret
    is_mret = 1'b1;
    tick();
    is_mret = 1'b0;
    redir_check(1'b1, 32'h40, "ret");
    rd_check(12'h300, 32'h88, "ret_mstatus");

    // External beats timer, vectored mode
    wr(12'h304, 32'h880); wr(12'h305, 32'h101);
    pc = 32'h80; ext_irq = 1'b1; timer_irq = 1'b1;
    tick();
    redir_check(1'b0, 32'd0, "pre_vec");
    ext_irq = 1'b0; timer_irq = 1'b0;
    redir_check(1'b1, 32'h12C, "trap_vec_ext");
    rd_check(12'h342, 32'h8000_000B, "vec_mcause");
    rd_check(12'h341, 32'h80, "vec_mepc");

    // mret wins over a simultaneous pending interrupt
    wr(12'h300, 32'h08);
    timer_irq = 1'b1;
    tick();
    is_mret = 1'b1;
    tick();
    is_mret = 1'b0;
    redir_check(1'b1, 32'h80, "ret_over_irq");
    rd_check(12'h342, 32'h8000_000B, "ret_mcause_kept");
    rd_check(12'h300, 32'h80, "ret_over_mstatus");

    // Trap discards a simultaneous CSR write
    wr(12'h300, 32'h08);
    csr_wr = 1'b1; addr = 12'h305; wdata = 32'hDEAD_0000; pc = 32'hC4;
    tick();
    csr_wr = 1'b0;
    redir_check(1'b1, 32'h11C, "trap_drop_wr");
    rd_check(12'h305, 32'h101, "mtvec_kept");
    rd_check(12'h341, 32'hC4, "drop_mepc");
    rd_check(12'h342, 32'h8000_0007, "drop_mcause");

    // Reset while in TRAP
    wr(12'h300, 32'h08);
    tick();
    rst = 1'b1; timer_irq = 1'b0;
    @(negedge clk);
    check("in_trap", {31'd0, epc_taken}, 32'd1);
    tick();
    rst = 1'b0;
    redir_check(1'b0, 32'd0, "rst_in_trap");
    rd_check(12'h300, 32'd0, "rst_mstatus");
    rd_check(12'h304, 32'd0, "rst_mie");
    rd_check(12'h305, 32'd0, "rst_mtvec");
    rd_check(12'h341, 32'd0, "rst_mepc");
    rd_check(12'h342, 32'd0, "rst_mcause");
    rd_check(12'h344, 32'd0, "rst_mip");

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_reg_file.md
CSR_REG_FILE -- requirements
Module: csr_reg_file

Interface
REQ-001 SHALL have: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: addr  in  12  CSR address from instruction bits [31:20].
REQ-004 SHALL have: wdata  in  32  CSR write data (rs1 value).
REQ-005 SHALL have: pc  in  32  PC of the instruction currently presenting csr_rd/csr_wr/is_mret.
REQ-006 SHALL have: csr_rd  in  1 and csr_wr  in  1  read/write strobes from the controller.
REQ-007 SHALL have: is_mret  in  1  current instruction is mret.
REQ-008 SHALL have: timer_irq  in  1 and ext_irq  in  1  level interrupt requests.
REQ-009 SHALL have: rdata  out  32  CSR read data.
REQ-010 SHALL have: epc_taken  out  1  one-cycle PC redirect request.
REQ-011 SHALL have: epc  out  32  redirect target, valid only when epc_taken=1.

Function
REQ-012 Implemented CSRs SHALL be: mstatus 0x300 (MIE bit3, MPIE bit7; other bits read 0), mie 0x304 (MTIE bit7, MEIE bit11), mtvec 0x305, mepc 0x341, mcause 0x342, mip 0x344.
REQ-013 rdata SHALL be combinational: the selected CSR when csr_rd=1; 0 when csr_rd=0 or addr is unimplemented.
REQ-014 With csr_wr=1 in state IDLE and no trap taken that cycle, the addressed CSR SHALL update at the next edge; read-only bits, mip, and unimplemented addresses SHALL ignore writes.
REQ-015 mepc bits [1:0] SHALL always read 0; written values SHALL be masked.
REQ-016 mip SHALL register timer_irq into MTIP (bit7) and ext_irq into MEIP (bit11) every cycle, giving 1-cycle input latency.
REQ-017 pending SHALL be mstatus.MIE & (mie & mip) non-zero; priority SHALL be external (cause 11) over timer (cause 7).
REQ-018 FSM states SHALL be IDLE, TRAP and RET.
REQ-019 In IDLE with is_mret=1: MIE<=MPIE, MPIE<=1, and the next state SHALL be RET; pending SHALL be ignored that cycle.
REQ-020 In IDLE with pending and is_mret=0: mepc<=pc, mcause<={1'b1, 27'b0, cause[3:0]}, MPIE<=MIE, MIE<=0, and the next state SHALL be TRAP; a simultaneous csr_wr SHALL be discarded.
REQ-021 In TRAP: epc_taken=1 and epc=mtvec base ({mtvec[31:2],2'b00}) if mtvec[1:0]=0, else base+4*cause; the next state SHALL be IDLE.
REQ-022 In RET: epc_taken=1 and epc=mepc; the next state SHALL be IDLE.
REQ-023 In TRAP and RET: csr_wr, is_mret and pending SHALL be ignored; rdata SHALL still follow REQ-013.
REQ-024 In IDLE: epc_taken=0 and epc=0.
REQ-025 A csr_rd+csr_wr pair to the same address SHALL return the old value on rdata; the new value SHALL be visible the next cycle.

Reset
REQ-026 When rst=1 at an edge, all CSRs, the mip copy, and epc SHALL be set to 0, epc_taken to 0, and the state to IDLE, overriding any in-progress trap or mret and any same-cycle write.

Verification
REQ-027 csr_wr=1, addr=0x305, wdata=0x0000_1001, then csr_rd=1 -> rdata=0x0000_1001; write 0x341 with 0x0000_2003 -> read 0x0000_2000.
REQ-028 mstatus=0x8, mie=0x80, mtvec=0x100, pc=0x40, timer_irq=1 -> TRAP two edges later: epc_taken=1, epc=0x100, mepc=0x40, mcause=0x8000_0007, mstatus=0x80.
REQ-029 Same setup with mtvec=0x101, ext_irq=1 and timer_irq=1, mie=0x880 -> epc=0x101&~3 + 44 = 0x12C, mcause=0x8000_000B.
REQ-030 After REQ-028, is_mret=1 -> next cycle epc_taken=1, epc=0x40, mstatus=0x88.
REQ-031 Pending interrupt and is_mret=1 in the same cycle -> RET taken, mcause unchanged; pending interrupt with csr_wr to 0x305 -> mtvec unchanged, trap taken.
REQ-032 Assert rst while in TRAP -> next cycle epc_taken=0 and all CSRs read 0.
